// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates two requesters onto the shared ALU, holds the
// operands for an opcode-dependent settle time and returns the result.
// Ports: clk, reset (async, active high); req_* two requester channels
// (valid/ready, opcode, a, b, carryin); alu_* registered ALU drive and
// ALU results; rsp_* backpressured response (valid/ready, id, out,
// extra, err); busy is high outside IDLE.
// Macro ALU_SCHED_STRICT_PRIO_EN: requester 0 always wins a tie
// (no round-robin pointer). Default build uses round-robin.
module alu_scheduler #(
  parameter int WIDTH      = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_opcode0,
  input  logic [3:0]       req_opcode1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_carryin,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_extra,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic [WIDTH-1:0] rsp_extra,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [3:0]       cnt;
  logic             gnt;
  logic             hs;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;
  logic [3:0]       lat;
  logic [WIDTH-1:0] cap_out;
  logic [WIDTH-1:0] cap_extra;
  logic             cap_err;
  logic             illegal;
  logic             divz;
  logic             short_op;

`ifdef ALU_SCHED_STRICT_PRIO_EN
  assign gnt = ~req_valid[0];
`else
  logic ptr;

  // pointer only matters on a tie
  assign gnt = (&req_valid) ? ptr : req_valid[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   ptr <= 1'b0;
    else if (hs) ptr <= ~gnt;
  end
`endif

  // reset gates req_ready so every output reads 0 while it is held
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !reset) begin
      req_ready = {gnt & req_valid[1],
                   ~gnt & req_valid[0]};
    end
  end

  assign hs = |req_ready;

  assign sel_op  = gnt ? req_opcode1 : req_opcode0;
  assign sel_a   = gnt ? req_a1 : req_a0;
  assign sel_b   = gnt ? req_b1 : req_b0;
  assign sel_cin = gnt ? req_carryin[1]
                       : req_carryin[0];

  always_comb begin
    lat = 4'd1;
    unique case (sel_op)
      4'b1001, 4'b1010, 4'b1011:
        lat = 4'(MULDIV_LAT);
      default: lat = 4'd1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs) state_nx = EXEC;
      EXEC: if (cnt == 4'd1) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign illegal  = alu_opcode[3:2] == 2'b11;
  assign divz     = (alu_opcode == 4'b1010)
                 && (alu_b == '0);
  assign short_op = alu_opcode <= 4'b0110;

  always_comb begin
    cap_out   = alu_out;
    cap_extra = alu_extra;
    cap_err   = 1'b0;
    unique case (1'b1)
      illegal: begin
        cap_out   = '0;
        cap_extra = '0;
        cap_err   = 1'b1;
      end
      divz: begin
        cap_out   = '1;
        cap_extra = alu_a;
        cap_err   = 1'b1;
      end
      short_op: cap_extra = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_carryin <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_out     <= '0;
      rsp_extra   <= '0;
      rsp_err     <= 1'b0;
      cnt         <= '0;
    end else begin
      if (hs) begin
        alu_opcode  <= sel_op;
        alu_a       <= sel_a;
        alu_b       <= sel_b;
        alu_carryin <= sel_cin;
        rsp_id      <= gnt;
        cnt         <= lat;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          rsp_out   <= cap_out;
          rsp_extra <= cap_extra;
          rsp_err   <= cap_err;
        end
      end
    end
  end

  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed stimulus with a scoreboard queue filled at
// each request handshake and drained by a response monitor.
module tb_alu_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_opcode0, req_opcode1;
  logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]   req_carryin;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_carryin;
  logic [W-1:0] alu_out, alu_extra;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_out, rsp_extra;
  logic         rsp_err;
  logic         busy;

  always #5 clk = ~clk;

  alu_scheduler #(.WIDTH(W), .MULDIV_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_carryin(req_carryin),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carryin(alu_carryin),
    .alu_out(alu_out), .alu_extra(alu_extra),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_extra(rsp_extra), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ALU stand-in; short opcodes and illegal ones drive junk in extra
  logic [4:0] sum;
  logic [7:0] prod;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_carryin};
    prod = {4'b0, alu_a} * {4'b0, alu_b};
    alu_out = 4'h6;
    alu_extra = 4'h9;
    case (alu_opcode)
      4'b0000: begin alu_out = alu_a & alu_b; alu_extra = 4'hA; end
      4'b0111: begin alu_out = sum[3:0]; alu_extra = {3'b0, sum[4]}; end
      4'b1000: begin alu_out = alu_a - alu_b; alu_extra = 4'hA; end
      4'b1001: begin alu_out = prod[7:4]; alu_extra = prod[3:0]; end
      4'b1010: begin
        if (alu_b != 4'd0) begin
          alu_out = alu_a / alu_b;
          alu_extra = alu_a % alu_b;
        end else begin
          alu_out = 4'h3;
          alu_extra = 4'h3;
        end
      end
      default: ;
    endcase
  end

  typedef struct {
    logic       id;
    logic [3:0] out;
    logic [3:0] extra;
    logic       err;
    int         lat;
    int         stamp;
  } exp_t;

  exp_t q[$];
  exp_t pend[2];
  exp_t e_in, e_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  logic       prev_v = 1'b0;
  logic       h_id, h_err;
  logic [3:0] h_out, h_extra;
  int         start = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_v = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e_in = pend[i];
          e_in.stamp = cyc;
          q.push_back(e_in);
        end
      end
      if (rsp_valid && !prev_v) start = cyc;
      if (rsp_valid && prev_v)
        chk("rsp_hold", {rsp_id, rsp_err, rsp_out, rsp_extra},
            {h_id, h_err, h_out, h_extra});
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual id=%0d out=%0h required none",
                   rsp_id, rsp_out);
        end else begin
          e_out = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e_out.id));
          chk("rsp_out", 32'(rsp_out), 32'(e_out.out));
          chk("rsp_extra", 32'(rsp_extra), 32'(e_out.extra));
          chk("rsp_err", 32'(rsp_err), 32'(e_out.err));
          chk("latency", 32'(start - e_out.stamp), 32'(e_out.lat));
        end
      end
      prev_v = rsp_valid && !rsp_ready;
      h_id = rsp_id;
      h_err = rsp_err;
      h_out = rsp_out;
      h_extra = rsp_extra;
    end
  end

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [3:0] eo,
                         input logic [3:0] ee, input logic er,
                         input int lat);
    if (i == 0) begin
      req_opcode0 = op; req_a0 = a; req_b0 = b;
    end else begin
      req_opcode1 = op; req_a1 = a; req_b1 = b;
    end
    req_carryin[i] = cin;
    pend[i].id = (i == 1);
    pend[i].out = eo;
    pend[i].extra = ee;
    pend[i].err = er;
    pend[i].lat = lat;
    pend[i].stamp = 0;
    req_valid[i] = 1'b1;
  endtask

  // call in the first half of a cycle
  task automatic wait_hs(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 60);
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout%0d actual ready=%b required grant", i,
               req_ready);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 100);
    if (busy || q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual busy=%0d pending=%0d required 0 0",
               busy, q.size());
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    req_valid = 2'b00;
    req_opcode0 = '0; req_opcode1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_carryin = 2'b00;
    rsp_ready = 1'b1;

    // both ADD from reset; R0 wins first
    set_req(0, 4'b0111, 4'd3, 4'd4, 1'b0, 4'd7, 4'd0, 1'b0, 2);
    set_req(1, 4'b0111, 4'd9, 4'd9, 1'b1, 4'd3, 4'd1, 1'b0, 2);
    @(negedge clk);
    chk("reset_outputs",
        {req_ready, alu_opcode, alu_a, alu_b, alu_carryin, rsp_valid,
         rsp_id, rsp_out, rsp_extra, rsp_err, busy}, 32'd0);
    sync();
    reset = 1'b0;
    #1 chk("arb_first", 32'(req_ready), 32'd1);
    wait_hs(0);
    wait_hs(1);
    wait_idle();

    // multiply 15*15 with operand stability
    sync();
    set_req(0, 4'b1001, 4'hF, 4'hF, 1'b0, 4'hE, 4'h1, 1'b0, 5);
    wait_hs(0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("mul_operands", {alu_a, alu_b}, 32'hFF);
    end
    wait_idle();

    // divide by zero
    sync();
    set_req(0, 4'b1010, 4'd7, 4'd0, 1'b0, 4'hF, 4'd7, 1'b1, 5);
    wait_hs(0);
    wait_idle();

    // illegal opcode
    sync();
    set_req(0, 4'b1101, 4'd5, 4'd6, 1'b0, 4'd0, 4'd0, 1'b1, 2);
    wait_hs(0);
    wait_idle();

    // subtract keeps extra; requester 1 alone
    sync();
    set_req(1, 4'b1000, 4'd2, 4'd5, 1'b0, 4'hD, 4'hA, 1'b0, 2);
    wait_hs(1);
    wait_idle();

    // backpressure with R1 waiting
    sync();
    rsp_ready = 1'b0;
    set_req(0, 4'b0000, 4'hC, 4'hA, 1'b0, 4'h8, 4'h0, 1'b0, 2);
    wait_hs(0);
    set_req(1, 4'b0111, 4'd1, 4'd2, 1'b0, 4'd3, 4'd0, 1'b0, 2);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 20);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    sync();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_cycle", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_r1_grant", 32'(req_ready), 32'd2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_idle();

    // reset in the middle of a divide (pointer is 1 here)
    sync();
    set_req(0, 4'b1010, 4'd7, 4'd3, 1'b0, 4'd2, 4'd1, 1'b0, 5);
    wait_hs(0);
    sync();
    set_req(0, 4'b0111, 4'd1, 4'd1, 1'b1, 4'd3, 4'd0, 1'b0, 2);
    set_req(1, 4'b0111, 4'd5, 4'd5, 1'b0, 4'hA, 4'd0, 1'b0, 2);
    reset = 1'b1;
    #1 chk("abort_outputs",
           {req_ready, alu_opcode, alu_a, alu_b, alu_carryin, rsp_valid,
            rsp_id, rsp_out, rsp_extra, rsp_err, busy}, 32'd0);
    sync();
    reset = 1'b0;
    #1 chk("arb_after_reset", 32'(req_ready), 32'd1);
    wait_hs(0);
    wait_hs(1);
    wait_idle();

    // round-robin: lone R0 grant, then tie goes to R1
    sync();
    set_req(0, 4'b1010, 4'd13, 4'd4, 1'b0, 4'd3, 4'd1, 1'b0, 5);
    wait_hs(0);
    wait_idle();
    sync();
    set_req(0, 4'b0111, 4'd2, 4'd2, 1'b0, 4'd4, 4'd0, 1'b0, 2);
    set_req(1, 4'b0111, 4'd8, 4'd8, 1'b0, 4'd0, 4'd1, 1'b0, 2);
    #1 chk("arb_rr", 32'(req_ready), 32'd2);
    wait_hs(1);
    wait_hs(0);
    wait_idle();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
